// File: rtl/mem_access.sv
// Memory-access stage: turns an EX-stage load/store into a single-beat bus
// transaction and produces the registered register-file writeback.
module mem_access #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_maddr,
    input  logic [31:0] ex_sdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_req,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        misalign_err,
    output logic        bus_err
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return !lo[0];
            OP_LW, OP_SW:         return (lo == 2'b00);
            default:              return 1'b1;
        endcase
    endfunction

    // Pick the addressed byte/half from the returned word and extend it.
    function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] lo,
                                             input logic [31:0] rdata);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   res = 32'(b);
            OP_LBU:  res = {24'h0, b};
            OP_LH:   res = 32'(h);
            OP_LHU:  res = {16'h0, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] sdata);
        case (op)
            OP_SB:   return {4{sdata[7:0]}};
            OP_SH:   return {2{sdata[15:0]}};
            OP_SW:   return sdata;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            OP_SB:   return 4'b0001 << lo;
            OP_SH:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Operation captured on entry to ACCESS; only consulted while there.
    logic [3:0] op_p1;
    logic [4:0] wd_p1;
    logic       wreg_p1;
    logic [1:0] lo_p1;

    logic        mem_op, accept, expire, latch_en, stall;
    logic        req_nxt, we_nxt, wb_we_nxt, mis_nxt, berr_nxt;
    logic [31:0] addr_nxt, wdata_nxt, wb_wdata_nxt;
    logic [3:0]  be_nxt;
    logic [4:0]  wb_waddr_nxt;

    assign mem_op = is_load(ex_memop) || is_store(ex_memop);
    assign accept = ex_valid && mem_op && is_aligned(ex_memop, ex_maddr[1:0]);
    assign expire = (cnt == CNT_LAST);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            mem_be       <= 4'h0;
            wb_we        <= 1'b0;
            wb_waddr     <= 5'h0;
            wb_wdata     <= 32'h0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            mem_req      <= req_nxt;
            mem_we       <= we_nxt;
            mem_addr     <= addr_nxt;
            mem_wdata    <= wdata_nxt;
            mem_be       <= be_nxt;
            wb_we        <= wb_we_nxt;
            wb_waddr     <= wb_waddr_nxt;
            wb_wdata     <= wb_wdata_nxt;
            misalign_err <= mis_nxt;
            bus_err      <= berr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            op_p1   <= ex_memop;
            wd_p1   <= ex_wd;
            wreg_p1 <= ex_wreg;
            lo_p1   <= ex_maddr[1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  if (mem_ack || expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall        = 1'b0;
        latch_en     = 1'b0;
        cnt_nxt      = cnt;
        req_nxt      = mem_req;
        we_nxt       = mem_we;
        addr_nxt     = mem_addr;
        wdata_nxt    = mem_wdata;
        be_nxt       = mem_be;
        wb_we_nxt    = 1'b0;
        wb_waddr_nxt = wb_waddr;
        wb_wdata_nxt = wb_wdata;
        mis_nxt      = 1'b0;
        berr_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid && !mem_op) begin
                    wb_we_nxt    = ex_wreg;
                    wb_waddr_nxt = ex_wd;
                    wb_wdata_nxt = ex_wdata;
                end else if (accept) begin
                    stall     = 1'b1;
                    latch_en  = 1'b1;
                    cnt_nxt   = '0;
                    req_nxt   = 1'b1;
                    we_nxt    = is_store(ex_memop);
                    addr_nxt  = {ex_maddr[31:2], 2'b00};
                    wdata_nxt = store_data(ex_memop, ex_sdata);
                    be_nxt    = store_be(ex_memop, ex_maddr[1:0]);
                end else if (ex_valid) begin
                    mis_nxt = 1'b1;
                end
            end
            ACCESS: begin
                stall = !mem_ack;
                if (mem_ack) begin
                    req_nxt = 1'b0;
                    cnt_nxt = '0;
                    if (is_load(op_p1)) begin
                        wb_we_nxt    = wreg_p1;
                        wb_waddr_nxt = wd_p1;
                        wb_wdata_nxt = load_ext(op_p1, lo_p1, mem_rdata);
                    end
                end else if (expire) begin
                    req_nxt  = 1'b0;
                    cnt_nxt  = '0;
                    berr_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign stall_req = rst && stall;

endmodule
